// File: rtl/uart_tx.sv
// rtl/uart_tx.sv - UART serial transmitter with start, LSB-first data, optional parity, stop.
module uart_tx #(
  parameter int DATA_WIDTH   = 8,
  parameter int CLKS_PER_BIT = 16
) (
  input  logic                  clk,
  input  logic                  arst_n,
  input  logic [DATA_WIDTH-1:0] tx_data,
  input  logic                  tx_valid,
  output logic                  tx_ready,
  input  logic                  par_en,
  input  logic                  par_type,
  output logic                  tx_out,
  output logic                  busy
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam int IDX_W = $clog2(DATA_WIDTH);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [IDX_W-1:0] LAST_BIT = IDX_W'(DATA_WIDTH - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_t;

  state_t                  state;
  logic [CNT_W-1:0]        cnt;
  logic [IDX_W-1:0]        bit_idx;
  logic [DATA_WIDTH-1:0]   shift_reg;
  logic                    par_en_q;
  logic                    par_bit;
  logic                    bit_end;

  assign bit_end = (cnt == CNT_MAX);

  // tx_out is loaded with the next bit's value on the edge that enters each state,
  // so the line changes in the same cycle as the state and never glitches.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      state     <= S_IDLE;
      cnt       <= '0;
      bit_idx   <= '0;
      shift_reg <= '0;
      par_en_q  <= 1'b0;
      par_bit   <= 1'b0;
      tx_out    <= 1'b1;
      tx_ready  <= 1'b1;
      busy      <= 1'b0;
    end else begin
      if (state == S_IDLE || bit_end) cnt <= '0;
      else                            cnt <= cnt + 1'b1;

      case (state)
        S_IDLE: begin
          tx_out <= 1'b1;
          if (tx_valid) begin
            shift_reg <= tx_data;
            par_en_q  <= par_en;
            par_bit   <= (^tx_data) ^ par_type;
            tx_out    <= 1'b0;
            tx_ready  <= 1'b0;
            busy      <= 1'b1;
            state     <= S_START;
          end
        end
        S_START: begin
          if (bit_end) begin
            bit_idx <= '0;
            tx_out  <= shift_reg[0];
            state   <= S_DATA;
          end
        end
        S_DATA: begin
          if (bit_end) begin
            if (bit_idx == LAST_BIT) begin
              if (par_en_q) begin
                tx_out <= par_bit;
                state  <= S_PARITY;
              end else begin
                tx_out <= 1'b1;
                state  <= S_STOP;
              end
            end else begin
              bit_idx   <= bit_idx + 1'b1;
              shift_reg <= {1'b0, shift_reg[DATA_WIDTH-1:1]};
              tx_out    <= shift_reg[1];
            end
          end
        end
        S_PARITY: begin
          if (bit_end) begin
            tx_out <= 1'b1;
            state  <= S_STOP;
          end
        end
        S_STOP: begin
          if (bit_end) begin
            tx_out   <= 1'b1;
            tx_ready <= 1'b1;
            busy     <= 1'b0;
            state    <= S_IDLE;
          end
        end
        default: begin
          tx_out   <= 1'b1;
          tx_ready <= 1'b1;
          busy     <= 1'b0;
          state    <= S_IDLE;
        end
      endcase
    end
  end

endmodule
